// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: address width,
// the NOP word loaded into the instruction register on reset, and the
// fetch FSM state encoding. ST_FAULT exists only when MISALIGN_CHECK_EN
// is defined.
package pc_fetch_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_READY
`ifdef MISALIGN_CHECK_EN
    , ST_FAULT
`endif
  } fetch_state_t;

  // Force an address onto a 4-byte boundary.
  function automatic addr_t word_align(input addr_t a);
    return a & ~addr_t'(32'h3);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage
// (master) and the instruction memory (slave).
interface pc_fetch_if;
  import pc_fetch_pkg::*;

  logic        ImemReq;
  addr_t       ImemAddr;
  logic        ImemGnt;
  logic        ImemRValid;
  logic [31:0] ImemRData;

  modport master (
    output ImemReq, ImemAddr,
    input  ImemGnt, ImemRValid, ImemRData
  );

  modport slave (
    input  ImemReq, ImemAddr,
    output ImemGnt, ImemRValid, ImemRData
  );

endinterface

// File: rtl/pc_fetch_timer.sv
// WAIT-state timeout counter. Counts enabled cycles from zero and flags
// expire during the TIMEOUT-th consecutive enabled cycle; clr returns the
// count to zero.
module pc_fetch_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned    CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TC = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Cycle counter, cleared whenever the FSM is outside WAIT or times out.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = en && (cnt == TC);

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: holds the PC, fetches the word at PC from
// instruction memory, and presents it until the core commits the next PC.
// Optional feature macro: MISALIGN_CHECK_EN (misaligned-target fault).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | one cycle after reset before the first request
// REQ      | ImemReq high with ImemAddr=Pc, waiting for ImemGnt
// WAIT     | granted, waiting for ImemRValid (bounded by WAIT_TIMEOUT)
// READY    | Instr valid for Pc, waiting for PcWe
// FAULT    | misaligned commit seen; stalled until reset (macro only)
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter addr_t       RESET_PC     = 32'h0000_0000,
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  addr_t       PcNext,
  input  logic        PcWe,
  pc_fetch_if.master  imem,
  output addr_t       Pc,
  output addr_t       PcPlus4,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic        FetchRetry
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        Misaligned
`endif
);

  fetch_state_t state, state_nxt;
  addr_t        pc_nxt;
  logic         capture;
  logic         retry_nxt;
  logic         wait_en;
  logic         wait_clr;
  logic         expire;

  assign wait_en  = (state == ST_WAIT);
  assign wait_clr = !wait_en || expire;

  pc_fetch_timer #(
    .TIMEOUT (WAIT_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (wait_en),
    .clr    (wait_clr),
    .expire (expire)
  );

  assign imem.ImemAddr = Pc;
  assign PcPlus4       = Pc + addr_t'(4);

  // Next-state, PC update and bus/handshake outputs.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = Pc;
    capture      = 1'b0;
    retry_nxt    = 1'b0;
    imem.ImemReq = 1'b0;
    InstrValid   = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        imem.ImemReq = 1'b1;
        if (imem.ImemGnt) begin
          if (imem.ImemRValid) begin
            capture   = 1'b1;
            state_nxt = ST_READY;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (imem.ImemRValid) begin
          capture   = 1'b1;
          state_nxt = ST_READY;
        end else if (expire) begin
          retry_nxt = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_READY: begin
        InstrValid = 1'b1;
        if (PcWe) begin
`ifdef MISALIGN_CHECK_EN
          if (PcNext[1:0] != 2'b00) begin
            state_nxt = ST_FAULT;
          end else begin
            pc_nxt    = word_align(PcNext);
            state_nxt = ST_REQ;
          end
`else
          pc_nxt    = word_align(PcNext);
          state_nxt = ST_REQ;
`endif
        end
      end
`ifdef MISALIGN_CHECK_EN
      ST_FAULT: state_nxt = ST_FAULT;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, PC, instruction hold register and retry pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      Pc         <= RESET_PC;
      Instr      <= NOP_INSTR;
      FetchRetry <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      Misaligned <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      Pc         <= pc_nxt;
      FetchRetry <= retry_nxt;
      if (capture) begin
        Instr <= imem.ImemRData;
      end
`ifdef MISALIGN_CHECK_EN
      Misaligned <= Misaligned | (state_nxt == ST_FAULT);
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed reset/handshake/timeout/wrap cases plus a
// randomized memory with variable grant and response latency. Expected
// (PC, instruction) pairs and expected retry cycles go into queues; a
// monitor pops and compares them whenever the DUT presents an output.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PcNext;
  logic        PcWe;
  logic [31:0] Pc;
  logic [31:0] PcPlus4;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        FetchRetry;
`ifdef MISALIGN_CHECK_EN
  logic        Misaligned;
`endif

  pc_fetch_if bus ();

  pc_fetch #(
    .RESET_PC     (RST_PC),
    .WAIT_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PcNext     (PcNext),
    .PcWe       (PcWe),
    .imem       (bus),
    .Pc         (Pc),
    .PcPlus4    (PcPlus4),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .FetchRetry (FetchRetry)
`ifdef MISALIGN_CHECK_EN
    ,
    .Misaligned (Misaligned)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t exp_q[$];
  int   retry_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_present = 0;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic fail_note(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compares each new instruction presentation and each retry pulse.
  logic prev_iv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (InstrValid && !prev_iv) begin
        if (exp_q.size() == 0) begin
          fail_note("instr_unexpected", Instr, 32'h0);
        end else begin
          e = exp_q.pop_front();
          n_present++;
          chk("present_pc", Pc, e.pc);
          chk("present_instr", Instr, e.instr);
          chk("present_pcplus4", PcPlus4, e.pc + 32'd4);
        end
      end
      if (FetchRetry) begin
        if (retry_q.size() == 0) fail_note("retry_unexpected", cyc, 32'h0);
        else chk("retry_cycle", cyc, retry_q.pop_front());
      end else if (retry_q.size() != 0 && retry_q[0] < cyc) begin
        fail_note("retry_missing", cyc, retry_q[0]);
        void'(retry_q.pop_front());
      end
    end
    prev_iv = InstrValid;
  end

  // Random memory and commit stimulus; model_pc is the architectural PC.
  task automatic auto_run(input int n);
    logic [31:0] model_pc = RST_PC;
    bit          outstanding = 1'b0;
    int          resp_cyc = 0;
    logic [31:0] out_addr = 32'h0;
    int          lat;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.ImemGnt    = 1'b0;
      bus.ImemRValid = 1'b0;
      bus.ImemRData  = $urandom;
      if (outstanding && cyc == resp_cyc) begin
        bus.ImemRValid = 1'b1;
        bus.ImemRData  = memword(out_addr);
        outstanding    = 1'b0;
      end else if (!outstanding && bus.ImemReq && $urandom_range(0, 1) == 1) begin
        chk("grant_addr", bus.ImemAddr, model_pc);
        bus.ImemGnt = 1'b1;
        lat = int'($urandom_range(0, 18));
        if (lat == 0) begin
          bus.ImemRValid = 1'b1;
          bus.ImemRData  = memword(bus.ImemAddr);
        end else if (lat <= 16) begin
          outstanding = 1'b1;
          resp_cyc    = cyc + lat;
          out_addr    = bus.ImemAddr;
        end else begin
          retry_q.push_back(cyc + 17);
        end
      end else if (!outstanding && retry_q.size() == 0 && $urandom_range(0, 7) == 0) begin
        bus.ImemRValid = 1'b1;
        bus.ImemRData  = 32'hBAD0_0000 | $urandom_range(0, 65535);
      end
      PcWe = 1'b0;
      PcNext = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        PcWe = 1'b1;
        case ($urandom_range(0, 5))
          0: PcNext = 32'hFFFF_FFFC;
          1: PcNext = 32'hFFFF_FFFF;
          2: PcNext = model_pc + 32'd4;
          default: PcNext = $urandom;
        endcase
`ifdef MISALIGN_CHECK_EN
        PcNext[1:0] = 2'b00;
`endif
        if (InstrValid) begin
          model_pc = PcNext & 32'hFFFF_FFFC;
          exp_q.push_back('{model_pc, memword(model_pc)});
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; PcWe = 1'b0; PcNext = 32'h0;
    bus.ImemGnt = 1'b0; bus.ImemRValid = 1'b0; bus.ImemRData = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_pc", Pc, RST_PC);
    chk1("rst_req", bus.ImemReq, 1'b0);
    chk1("rst_ivalid", InstrValid, 1'b0);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk1("rst_retry", FetchRetry, 1'b0);
`ifdef MISALIGN_CHECK_EN
    chk1("rst_misaligned", Misaligned, 1'b0);
`endif
    exp_q.push_back('{RST_PC, 32'h0050_0093});
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("idle_req", bus.ImemReq, 1'b0);
    @(negedge clk);
    chk1("first_req", bus.ImemReq, 1'b1);
    chk("first_addr", bus.ImemAddr, RST_PC);
    chk("first_instr_nop", Instr, 32'h0000_0013);
    bus.ImemGnt = 1'b1; bus.ImemRValid = 1'b1; bus.ImemRData = 32'h0050_0093;
    @(negedge clk);
    bus.ImemGnt = 1'b0; bus.ImemRValid = 1'b0;
    chk1("ready_ivalid", InstrValid, 1'b1);
    chk("ready_pcplus4", PcPlus4, 32'h0000_0104);
    PcWe = 1'b1; PcNext = 32'h0000_0200;
    exp_q.push_back('{32'h0000_0200, 32'h00A0_0113});
    @(negedge clk);
    PcWe = 1'b0;
    chk("commit_pc", Pc, 32'h0000_0200);
    chk1("commit_ivalid", InstrValid, 1'b0);
    chk1("commit_req", bus.ImemReq, 1'b1);
    chk("commit_addr", bus.ImemAddr, 32'h0000_0200);
    bus.ImemGnt = 1'b1;
    retry_q.push_back(cyc + 17);
    @(negedge clk);
    bus.ImemGnt = 1'b0;
    chk1("wait_req", bus.ImemReq, 1'b0);
    PcWe = 1'b1; PcNext = 32'h0000_0300;
    @(negedge clk);
    PcWe = 1'b0;
    chk("wait_pcwe_pc", Pc, 32'h0000_0200);
    repeat (14) @(negedge clk);
    chk1("retry_early", FetchRetry, 1'b0);
    @(negedge clk);
    chk1("retry_pulse", FetchRetry, 1'b1);
    chk1("retry_req", bus.ImemReq, 1'b1);
    chk("retry_addr", bus.ImemAddr, 32'h0000_0200);
    bus.ImemRValid = 1'b1; bus.ImemRData = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.ImemRValid = 1'b0;
    chk1("retry_once", FetchRetry, 1'b0);
    chk1("stale_ivalid", InstrValid, 1'b0);
    chk1("stale_req", bus.ImemReq, 1'b1);
    bus.ImemGnt = 1'b1; bus.ImemRValid = 1'b1; bus.ImemRData = 32'h00A0_0113;
    @(negedge clk);
    bus.ImemGnt = 1'b0; bus.ImemRValid = 1'b0;
    chk1("refetch_ivalid", InstrValid, 1'b1);
    PcWe = 1'b1; PcNext = 32'h0000_0040;
    @(negedge clk);
    PcWe = 1'b0;
    bus.ImemGnt = 1'b1;
    @(negedge clk);
    bus.ImemGnt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); retry_q.delete();
    @(negedge clk);
    chk1("rstwait_req", bus.ImemReq, 1'b0);
    chk("rstwait_instr", Instr, 32'h0000_0013);
    rst = 1'b0;
    bus.ImemRValid = 1'b1; bus.ImemRData = 32'hDEAD_BEEF;
    @(negedge clk);
    chk1("after_rst_req", bus.ImemReq, 1'b1);
    chk("after_rst_pc", Pc, RST_PC);
    @(negedge clk);
    bus.ImemRValid = 1'b0;
    chk1("after_rst_ivalid", InstrValid, 1'b0);
    chk("after_rst_instr", Instr, 32'h0000_0013);
    exp_q.push_back('{RST_PC, memword(RST_PC)});

    auto_run(3000);

    @(negedge clk);
    bus.ImemGnt = 1'b0; bus.ImemRValid = 1'b0; PcWe = 1'b0;
    rst = 1'b1;
    exp_q.delete(); retry_q.delete();
    chk1("random_progress", n_present >= 50, 1'b1);
    exp_q.push_back('{RST_PC, 32'h1111_1111});
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.ImemGnt = 1'b1; bus.ImemRValid = 1'b1; bus.ImemRData = 32'h1111_1111;
    @(negedge clk);
    bus.ImemGnt = 1'b0; bus.ImemRValid = 1'b0;
    PcWe = 1'b1; PcNext = 32'hFFFF_FFFC;
    exp_q.push_back('{32'hFFFF_FFFC, 32'h2222_2222});
    @(negedge clk);
    PcWe = 1'b0;
    chk("wrap_addr", bus.ImemAddr, 32'hFFFF_FFFC);
    bus.ImemGnt = 1'b1; bus.ImemRValid = 1'b1; bus.ImemRData = 32'h2222_2222;
    @(negedge clk);
    bus.ImemGnt = 1'b0; bus.ImemRValid = 1'b0;
    chk("wrap_pcplus4", PcPlus4, 32'h0000_0000);
    chk("wrap_pc", Pc, 32'hFFFF_FFFC);
    PcWe = 1'b1; PcNext = 32'h0000_0202;
`ifdef MISALIGN_CHECK_EN
    @(negedge clk);
    PcWe = 1'b0;
    chk1("mis_flag", Misaligned, 1'b1);
    chk("mis_pc", Pc, 32'hFFFF_FFFC);
    chk1("mis_req", bus.ImemReq, 1'b0);
    chk1("mis_ivalid", InstrValid, 1'b0);
    bus.ImemGnt = 1'b1; bus.ImemRValid = 1'b1; bus.ImemRData = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    bus.ImemGnt = 1'b0; bus.ImemRValid = 1'b0;
    chk1("mis_sticky", Misaligned, 1'b1);
    chk1("mis_req_hold", bus.ImemReq, 1'b0);
    chk1("mis_ivalid_hold", InstrValid, 1'b0);
`else
    exp_q.push_back('{32'h0000_0200, 32'h3333_3333});
    @(negedge clk);
    PcWe = 1'b0;
    chk("align_pc", Pc, 32'h0000_0200);
    chk1("align_req", bus.ImemReq, 1'b1);
    chk("align_addr", bus.ImemAddr, 32'h0000_0200);
    bus.ImemGnt = 1'b1; bus.ImemRValid = 1'b1; bus.ImemRData = 32'h3333_3333;
    @(negedge clk);
    bus.ImemGnt = 1'b0; bus.ImemRValid = 1'b0;
    chk1("align_ivalid", InstrValid, 1'b1);
`endif
    @(negedge clk);
    chk1("queue_drained", exp_q.size() == 0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Parameter WAIT_TIMEOUT, default 16, SHALL set the maximum cycles spent in WAIT before re-issuing the fetch.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 PcNext  in  32  SHALL carry the next PC from the PC-select mux.
REQ-006 PcWe  in  1  SHALL be the commit strobe; the current instruction retires and PcNext is loaded.
REQ-007 ImemReq  out  1  SHALL be the instruction-memory request valid.
REQ-008 ImemAddr  out  32  SHALL be the fetch address; equals Pc while ImemReq=1.
REQ-009 ImemGnt  in  1  SHALL be the memory accept (ready) for ImemReq.
REQ-010 ImemRValid  in  1  SHALL flag valid read data on ImemRData.
REQ-011 ImemRData  in  32  SHALL be the fetched instruction word.
REQ-012 Pc  out  32  SHALL be the registered current PC.
REQ-013 PcPlus4  out  32  SHALL be Pc+4, combinational, modulo 2^32.
REQ-014 Instr  out  32  SHALL be the held instruction word.
REQ-015 InstrValid  out  1  SHALL be high only when Instr corresponds to Pc.
REQ-016 FetchRetry  out  1  SHALL pulse one cycle when a timeout re-issue occurs.
REQ-017 Misaligned  out  1  SHALL exist only when MISALIGN_CHECK_EN is defined.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, READY (plus FAULT with MISALIGN_CHECK_EN).
REQ-019 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-020 REQ SHALL drive ImemReq=1, ImemAddr=Pc, and hold both stable until ImemGnt=1.
REQ-021 REQ with ImemGnt=1 and ImemRValid=0 SHALL go to WAIT; with both high same cycle SHALL capture ImemRData and go to READY.
REQ-022 WAIT SHALL capture ImemRData into Instr on ImemRValid=1 and go to READY next cycle.
REQ-023 WAIT SHALL count cycles; on reaching WAIT_TIMEOUT without ImemRValid it SHALL return to REQ, pulse FetchRetry, and clear the counter.
REQ-024 ImemRValid outside WAIT (or REQ with ImemGnt) SHALL be ignored.
REQ-025 READY SHALL assert InstrValid=1 and hold Instr, Pc until PcWe=1.
REQ-026 READY with PcWe=1 SHALL load Pc<=PcNext, deassert InstrValid next cycle, and go to REQ.
REQ-027 PcWe in IDLE, REQ or WAIT SHALL be ignored; Pc SHALL NOT change.
REQ-028 Minimum latency PcWe to next InstrValid SHALL be 2 cycles (REQ with same-cycle Gnt+RValid, then READY).
REQ-029 PcPlus4 at Pc=32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.

Reset
REQ-030 On rst=1 at a clock edge: Pc=RESET_PC, state=IDLE, ImemReq=0, InstrValid=0, FetchRetry=0, Instr=32'h0000_0013 (NOP), timeout counter=0, Misaligned=0.
REQ-031 rst mid-fetch SHALL abandon the outstanding request; any later ImemRValid SHALL be ignored until the next grant.

Configuration
REQ-032 With MISALIGN_CHECK_EN defined: READY with PcWe=1 and PcNext[1:0]!=0 SHALL leave Pc unchanged, set Misaligned=1 and enter FAULT.
REQ-033 FAULT SHALL keep ImemReq=0 and InstrValid=0, with Misaligned sticky, until reset.
REQ-034 Without MISALIGN_CHECK_EN: Pc SHALL load {PcNext[31:2],2'b00}, the Misaligned port and FAULT SHALL be absent.

Structure
REQ-035 The fetch-state enum, NOP constant 32'h0000_0013 and the 32-bit address width SHALL live in the shared core package.
REQ-036 A sub-module pc_fetch_timer SHALL implement the WAIT timeout counter with clear and expire outputs.

Verification
REQ-037 Reset with RESET_PC=32'h100, release -> IDLE 1 cycle, then ImemReq=1, ImemAddr=32'h100, Instr=32'h13 before fetch.
REQ-038 Gnt+RValid same cycle, RData=32'h00500093 -> next cycle InstrValid=1, Instr=32'h00500093, PcPlus4=32'h104.
REQ-039 PcWe with PcNext=32'h200 in READY -> Pc=32'h200, InstrValid=0, ImemAddr=32'h200; PcWe during WAIT -> Pc unchanged.
REQ-040 Gnt then no RValid for 16 cycles -> FetchRetry one-cycle pulse, ImemReq=1 again with same address; stale RValid in REQ ignored.
REQ-041 MISALIGN_CHECK_EN, PcNext=32'h202 -> Misaligned=1, Pc held, ImemReq=0; without macro -> Pc=32'h200.
REQ-042 Pc=32'hFFFF_FFFC -> PcPlus4=32'h0; rst asserted in WAIT -> state IDLE, subsequent RValid ignored.
